// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage access controller.
// The controller takes the master modport; the pipeline/memory environment takes slave.
interface mem_access_ctrl_if #(
  parameter int N_BITS = 32
);
  logic              i_valid;
  logic [N_BITS-1:0] i_aluResult;
  logic [N_BITS-1:0] i_storeData;
  logic              i_memRead;
  logic              i_memWrite;
  logic [1:0]        i_size;
  logic              i_unsigned;
  logic              o_memReq;
  logic              o_memWe;
  logic [N_BITS-1:0] o_memAddr;
  logic [N_BITS-1:0] o_memWdata;
  logic [3:0]        o_memBe;
  logic [N_BITS-1:0] i_memRdata;
  logic              i_memAck;
  logic              o_stall;
  logic [N_BITS-1:0] o_loadData;
  logic              o_loadValid;
  logic              o_misaligned;
  logic              o_busError;

  modport master (
    input  i_valid, i_aluResult, i_storeData,
    input  i_memRead, i_memWrite, i_size, i_unsigned,
    input  i_memRdata, i_memAck,
    output o_memReq, o_memWe, o_memAddr, o_memWdata, o_memBe,
    output o_stall, o_loadData, o_loadValid,
    output o_misaligned, o_busError
  );

  modport slave (
    output i_valid, i_aluResult, i_storeData,
    output i_memRead, i_memWrite, i_size, i_unsigned,
    output i_memRdata, i_memAck,
    input  o_memReq, o_memWe, o_memAddr, o_memWdata, o_memBe,
    input  o_stall, o_loadData, o_loadValid,
    input  o_misaligned, o_busError
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory controller: req/ack bus, byte lanes, load extension.
// Define MEM_ACCESS_TIMEOUT_EN to add a BUSY timeout raising o_busError.
module mem_access_ctrl #(
  parameter int N_BITS         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               i_clock,
  input logic               i_reset,
  mem_access_ctrl_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] addr_q, wdata_q, ld_q;
  logic [3:0]        be_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q, off_q;
  logic              lv_q, mis_q;

  logic              start, aligned, accept, mis;
  logic              busy, ack, stall, tmo;
  logic [1:0]        off;
  logic              is_word, is_half;
  logic [3:0]        be_d;
  logic [N_BITS-1:0] wdata_d, ld_d;
  logic [7:0]        b_lane;
  logic [15:0]       h_lane;

  assign off     = bus.i_aluResult[1:0];
  assign is_word = bus.i_size[1];
  assign is_half = bus.i_size == 2'b01;
  assign start   = bus.i_valid &
                   (bus.i_memRead | bus.i_memWrite);
  assign aligned = is_word ? (off == 2'b00) :
                   is_half ? ~off[0] : 1'b1;
  assign busy    = state_q == BUSY;
  assign ack     = busy & bus.i_memAck;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Ack on the limit cycle wins: tmo only fires without ack.
  assign tmo = busy & ~bus.i_memAck &
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo;
      if (accept)
        cnt_q <= '0;
      else if (busy & ~bus.i_memAck)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.o_busError = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES > 0;
  assign tmo            = 1'b0;
  assign bus.o_busError = 1'b0;
`endif

  always_comb begin
    be_d    = 4'hF;
    wdata_d = bus.i_storeData;
    if (bus.i_memWrite) begin
      unique case (1'b1)
        is_word: begin
          be_d    = 4'hF;
          wdata_d = bus.i_storeData;
        end
        is_half: begin
          be_d    = off[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{bus.i_storeData[15:0]}};
        end
        default: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{bus.i_storeData[7:0]}};
        end
      endcase
    end
  end

  assign b_lane = bus.i_memRdata[{off_q, 3'b000} +: 8];
  assign h_lane = bus.i_memRdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_d = bus.i_memRdata;
    unique case (1'b1)
      size_q[1]:
        ld_d = bus.i_memRdata;
      (size_q == 2'b01):
        ld_d = {{(N_BITS-16){~uns_q & h_lane[15]}}, h_lane};
      default:
        ld_d = {{(N_BITS-8){~uns_q & b_lane[7]}}, b_lane};
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    accept  = 1'b0;
    mis     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (aligned) begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = BUSY;
          end else begin
            mis = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = ~bus.i_memAck;
        if (bus.i_memAck | tmo)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      ld_q    <= '0;
      lv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lv_q    <= 1'b0;
      mis_q   <= mis;
      if (accept) begin
        addr_q  <= {bus.i_aluResult[N_BITS-1:2], 2'b00};
        wdata_q <= wdata_d;
        be_q    <= be_d;
        we_q    <= bus.i_memWrite;
        uns_q   <= bus.i_unsigned;
        size_q  <= bus.i_size;
        off_q   <= off;
      end
      if (ack & ~we_q) begin
        ld_q <= ld_d;
        lv_q <= 1'b1;
      end
    end
  end

  assign bus.o_memReq     = busy;
  assign bus.o_memWe      = busy & we_q;
  assign bus.o_memAddr    = addr_q;
  assign bus.o_memWdata   = wdata_q;
  assign bus.o_memBe      = be_q;
  assign bus.o_stall      = stall;
  assign bus.o_loadData   = ld_q;
  assign bus.o_loadValid  = lv_q;
  assign bus.o_misaligned = mis_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed plan cases plus random accesses
// against a transaction-level model of lanes, extension and stall length.
module tb_mem_access_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.N_BITS(32)) bus ();

  mem_access_ctrl #(
    .N_BITS(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus.master)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic        exp_req = 0, exp_stall = 0, exp_we = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;
  logic        pend_lv = 0, pend_mis = 0, pend_err = 0;
  logic [31:0] pend_ld = 0;
  logic        nxt_lv = 0, nxt_mis = 0, nxt_err = 0;
  logic [31:0] nxt_ld = 0;

  int          stall_cnt = 0, req_cnt = 0, mis_cnt = 0;
  int          lv_cnt = 0;
  logic [31:0] last_addr = 0, last_wdata = 0, last_ld = 0;
  logic [3:0]  last_be = 0;
  logic        last_we = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(logic [1:0] sz);
    return sz[1] ? 4 : (sz[0] ? 2 : 1);
  endfunction

  function automatic bit is_aligned(logic [31:0] a,
                                    logic [1:0] sz);
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] m_be(bit rd, logic [31:0] a,
                                      logic [1:0] sz);
    int mask;
    if (rd) return 4'hF;
    mask = (1 << nbytes(sz)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] d,
                                          logic [1:0] sz);
    case (nbytes(sz))
      1:       return {24'h0, d[7:0]} * 32'h0101_0101;
      2:       return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] r,
                                         logic [31:0] a,
                                         logic [1:0] sz,
                                         bit u);
    logic [31:0] v, mask;
    int bits;
    bits = 8 * nbytes(sz);
    if (bits == 32) return r;
    v    = r >> (8 * (a % 4));
    mask = (32'h1 << bits) - 1;
    v    = v & mask;
    if (!u && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    chk("req", {31'h0, bus.o_memReq}, {31'h0, exp_req});
    chk("stall", {31'h0, bus.o_stall}, {31'h0, exp_stall});
    if (exp_req) begin
      chk("we", {31'h0, bus.o_memWe}, {31'h0, exp_we});
      chk("addr", bus.o_memAddr, exp_addr);
      chk("be", {28'h0, bus.o_memBe}, {28'h0, exp_be});
      if (exp_we) chk("wdata", bus.o_memWdata, exp_wdata);
    end
    chk("load_valid", {31'h0, bus.o_loadValid},
        {31'h0, pend_lv});
    if (pend_lv) chk("load_data", bus.o_loadData, pend_ld);
    chk("misaligned", {31'h0, bus.o_misaligned},
        {31'h0, pend_mis});
    chk("bus_error", {31'h0, bus.o_busError},
        {31'h0, pend_err});
    if (bus.o_stall) stall_cnt++;
    if (bus.o_memReq) begin
      req_cnt++;
      last_addr  = bus.o_memAddr;
      last_be    = bus.o_memBe;
      last_wdata = bus.o_memWdata;
      last_we    = bus.o_memWe;
    end
    if (bus.o_loadValid) begin
      lv_cnt++;
      last_ld = bus.o_loadData;
    end
    if (bus.o_misaligned) mis_cnt++;
    pend_lv  = nxt_lv;
    pend_ld  = nxt_ld;
    pend_mis = nxt_mis;
    pend_err = nxt_err;
    nxt_lv   = 0;
    nxt_mis  = 0;
    nxt_err  = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid    = 0;
    bus.i_memRead  = 0;
    bus.i_memWrite = 0;
    bus.i_memAck   = 1'($urandom_range(0, 1));
    bus.i_memRdata = $urandom;
    exp_req        = 0;
    exp_stall      = 0;
    step();
    bus.i_memAck   = 0;
  endtask

  task automatic issue(bit rd, logic [31:0] a,
                       logic [31:0] d, logic [1:0] sz,
                       bit u);
    bus.i_valid     = 1;
    bus.i_memRead   = rd;
    bus.i_memWrite  = ~rd;
    bus.i_aluResult = a;
    bus.i_storeData = d;
    bus.i_size      = sz;
    bus.i_unsigned  = u;
    bus.i_memAck    = 0;
  endtask

  task automatic scramble();
    bus.i_valid     = 1'($urandom_range(0, 1));
    bus.i_aluResult = $urandom;
    bus.i_storeData = $urandom;
    bus.i_size      = 2'($urandom_range(0, 3));
    bus.i_unsigned  = 1'($urandom_range(0, 1));
    bus.i_memRead   = 1'($urandom_range(0, 1));
    bus.i_memWrite  = ~bus.i_memRead;
  endtask

  task automatic access(bit rd, logic [31:0] a,
                        logic [31:0] d, logic [1:0] sz,
                        bit u, int w, logic [31:0] r);
    bit al;
    al = is_aligned(a, sz);
    issue(rd, a, d, sz, u);
    exp_req   = 0;
    exp_stall = al;
    if (!al) begin
      nxt_mis = 1;
      step();
      bus.i_valid = 0;
      return;
    end
    step();
    exp_req   = 1;
    exp_we    = ~rd;
    exp_addr  = a & ~32'h3;
    exp_be    = m_be(rd, a, sz);
    exp_wdata = m_wdata(d, sz);
    for (int i = 0; i <= w; i++) begin
      scramble();
      bus.i_memAck   = (i == w);
      bus.i_memRdata = (i == w) ? r : $urandom;
      exp_stall      = (i != w);
      if (i == w && rd) begin
        nxt_lv = 1;
        nxt_ld = m_load(r, a, sz, u);
      end
      step();
    end
    bus.i_memAck   = 0;
    bus.i_valid    = 0;
    bus.i_memRead  = 0;
    bus.i_memWrite = 0;
    exp_req        = 0;
    exp_stall      = 0;
  endtask

  logic        r_rd, r_u;
  logic [1:0]  r_sz;
  logic [31:0] r_a, r_d, r_r;
  int          r_w, lv_before;

  initial begin
    rst             = 1;
    bus.i_valid     = 0;
    bus.i_aluResult = 0;
    bus.i_storeData = 0;
    bus.i_memRead   = 0;
    bus.i_memWrite  = 0;
    bus.i_size      = 0;
    bus.i_unsigned  = 0;
    bus.i_memRdata  = 0;
    bus.i_memAck    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'h0, bus.o_memReq}, 32'h0);
    chk("rst_we", {31'h0, bus.o_memWe}, 32'h0);
    chk("rst_addr", bus.o_memAddr, 32'h0);
    chk("rst_wdata", bus.o_memWdata, 32'h0);
    chk("rst_be", {28'h0, bus.o_memBe}, 32'h0);
    chk("rst_stall", {31'h0, bus.o_stall}, 32'h0);
    chk("rst_ld", bus.o_loadData, 32'h0);
    chk("rst_lv", {31'h0, bus.o_loadValid}, 32'h0);
    chk("rst_mis", {31'h0, bus.o_misaligned}, 32'h0);
    chk("rst_err", {31'h0, bus.o_busError}, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    idle();

    // LBU 0x1003, no wait states
    stall_cnt = 0;
    access(1, 32'h1003, 0, 2'b00, 1, 0, 32'h80FF_1234);
    idle();
    chk("lbu_addr", last_addr, 32'h0000_1000);
    chk("lbu_data", last_ld, 32'h0000_0080);
    chk("lbu_stall_cycles", stall_cnt, 1);

    // LH 0x2002 signed, 3 wait states
    stall_cnt = 0;
    access(1, 32'h2002, 0, 2'b01, 0, 3, 32'h8001_0000);
    idle();
    chk("lh_data", last_ld, 32'hFFFF_8001);
    chk("lh_stall_cycles", stall_cnt, 4);

    // SB 0x3001
    lv_before = lv_cnt;
    access(0, 32'h3001, 32'h0000_00AB, 2'b00, 0, 1, 0);
    idle();
    chk("sb_be", {28'h0, last_be}, 32'h2);
    chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
    chk("sb_we", {31'h0, last_we}, 32'h1);
    chk("sb_no_lv", lv_cnt - lv_before, 0);

    // SW 0x4002 misaligned
    stall_cnt = 0;
    req_cnt   = 0;
    mis_cnt   = 0;
    access(0, 32'h4002, 32'h1234_5678, 2'b10, 0, 0, 0);
    idle();
    idle();
    chk("sw_mis_pulses", mis_cnt, 1);
    chk("sw_no_req", req_cnt, 0);
    chk("sw_no_stall", stall_cnt, 0);

    // Reset on the second BUSY cycle of a load
    lv_before = lv_cnt;
    issue(1, 32'h5000, 0, 2'b10, 0);
    exp_req   = 0;
    exp_stall = 1;
    step();
    bus.i_valid = 0;
    exp_req     = 1;
    exp_we      = 0;
    exp_addr    = 32'h5000;
    exp_be      = 4'hF;
    step();
    rst = 1;
    step();
    rst       = 0;
    exp_req   = 0;
    exp_stall = 0;
    step();
    bus.i_memAck   = 1;
    bus.i_memRdata = $urandom;
    step();
    bus.i_memAck = 0;
    step();
    chk("rst_busy_no_lv", lv_cnt - lv_before, 0);

    // Random accesses, some back-to-back
    for (int k = 0; k < 60; k++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      if ($urandom_range(0, 3) != 0)
        r_a = r_a & ~32'(nbytes(r_sz) - 1);
      r_d = $urandom;
      r_u = 1'($urandom_range(0, 1));
      r_w = $urandom_range(0, 4);
      r_r = $urandom;
      access(r_rd, r_a, r_d, r_sz, r_u, r_w, r_r);
      if ($urandom_range(0, 1) != 0) idle();
    end
    idle();
    idle();

    // Access never acknowledged
    lv_before = lv_cnt;
    issue(1, 32'h6000, 0, 2'b10, 0);
    exp_req   = 0;
    exp_stall = 1;
    step();
    bus.i_valid = 0;
    exp_req     = 1;
    exp_we      = 0;
    exp_addr    = 32'h6000;
    exp_be      = 4'hF;
`ifdef MEM_ACCESS_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      if (i == TMO - 1) nxt_err = 1;
      step();
    end
    exp_req   = 0;
    exp_stall = 0;
    step();
    idle();
    chk("tmo_no_lv", lv_cnt - lv_before, 0);
`else
    for (int i = 0; i < 100; i++) step();
    chk("stall_at_100", {31'h0, bus.o_stall}, 32'h1);
    chk("req_at_100", {31'h0, bus.o_memReq}, 32'h1);
    rst = 1;
    step();
    rst       = 0;
    exp_req   = 0;
    exp_stall = 0;
    idle();
    chk("hang_no_lv", lv_cnt - lv_before, 0);
`endif
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
